commit_checker: RTL
===================

COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the width of the PC and register data.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning the register index width.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning expected-event FIFO entries; it is a power of 2 and at least 2.
REQ-004 The block SHALL have parameter END_COUNT, default 50, meaning retirements needed to finish.
REQ-005 The block SHALL have parameter TIMEOUT, default 64, meaning the watchdog limit in cycles.
REQ-006 The block SHALL have ports, with clock and reset first:
  clk_i in 1: single clock.
  rst_i in 1: synchronous, active-high reset.
  exp_valid_i in 1: golden-model event valid.
  exp_ready_o out 1: the FIFO can accept an event.
  exp_pc_i in XLEN: expected next PC.
  exp_we_i in 1: expected register write.
  exp_rd_i in REG_AW: expected destination register.
  exp_wdata_i in XLEN: expected write data.
  dut_valid_i in 1: DUT retire event valid.
  dut_ready_o out 1: the checker consumes the DUT event this cycle.
  dut_pc_i, dut_we_i, dut_rd_i, dut_wdata_i: as the exp_* ports, from the DUT.
  halt_i in 1: the next fetched instruction is all-zero.
  done_o out 1: the run completed with no error.
  err_o out 1: sticky mismatch flag.
  err_kind_o out 2: 0 none, 1 PC, 2 write-enable or rd, 3 data or timeout.
  err_idx_o out 16: retirement index of the first error.
  retired_o out 16: count of compared events.

Function
REQ-007 The FSM SHALL have four states: IDLE, RUN, DONE, FAIL.
REQ-008 The FSM SHALL move from IDLE to RUN on the first cycle exp_valid_i or dut_valid_i is 1.
REQ-009 exp_ready_o SHALL equal (FIFO not full) OR (a pop occurs this cycle), so push and pop are allowed together when full; it SHALL be 0 in DONE and FAIL.
REQ-010 A push SHALL occur when exp_valid_i and exp_ready_o are both 1; the write pointer wraps modulo DEPTH.
REQ-011 dut_ready_o SHALL be 1 only in RUN with the FIFO not empty; it is combinational.
REQ-012 The block SHALL compare when dut_valid_i and dut_ready_o are both 1, and SHALL pop the FIFO head on the same edge.
REQ-013 An event with we=1 and rd=0 SHALL be treated as we=0 on both sides before comparison.
REQ-014 Comparison priority SHALL be: PC mismatch gives kind 1; else we or rd mismatch gives kind 2; else, if we=1, data mismatch gives kind 3.
REQ-015 On the edge after a mismatch, the block SHALL enter FAIL, set err_o=1, latch err_kind_o, and latch err_idx_o = retired_o before increment.
REQ-016 On a matching compare, retired_o SHALL increment by 1, saturating at 16'hFFFF.
REQ-017 The FSM SHALL go from RUN to DONE when retired_o reaches END_COUNT, or when halt_i=1 on a cycle with a matching compare.
REQ-018 If a mismatch and the DONE condition occur in the same cycle, FAIL SHALL win.
REQ-019 DONE and FAIL SHALL be absorbing until rst_i; done_o=1 only in DONE.
REQ-020 In DONE and FAIL, no compares, pushes or pops SHALL occur.
REQ-021 A dut_valid_i with the FIFO empty SHALL stall; it is not an error.

Reset
REQ-022 When rst_i=1 at a rising clk_i edge, the block SHALL enter IDLE, empty the FIFO, and clear every output register.
REQ-023 After reset: done_o=0, err_o=0, err_kind_o=0, err_idx_o=0, retired_o=0, watchdog=0.
REQ-024 Reset SHALL take effect in any state, including mid-compare; an in-flight event SHALL be discarded.

Configuration
REQ-025 With COMMIT_CHK_TIMEOUT_EN defined, a watchdog SHALL count RUN cycles without a compare and clear on each compare.
REQ-026 When the watchdog reaches TIMEOUT, the block SHALL enter FAIL with err_kind_o=3 and err_idx_o=retired_o.
REQ-027 Without COMMIT_CHK_TIMEOUT_EN, no watchdog logic SHALL exist, and a stall SHALL persist indefinitely.

Verification
REQ-028 Bench SHALL cover match run: 50 identical events (pc 4,8,...,200; rd=1; data=i), END_COUNT=50 -> done_o=1 in the cycle after the 50th compare, retired_o=50, err_o=0.
REQ-029 Bench SHALL cover PC error: event 3 with exp_pc=16, dut_pc=20 -> FAIL, err_kind_o=1, err_idx_o=3, dut_ready_o=0 afterwards.
REQ-030 Bench SHALL cover r0 masking: exp we=0; dut we=1, rd=0, data=32'hDEAD -> match, retired_o increments by 1.
REQ-031 Bench SHALL cover full FIFO: push 8 events with no DUT traffic -> exp_ready_o=0; then simultaneous push and pop -> accepted, occupancy stays 8, with wrap.
REQ-032 Bench SHALL cover halt and conflict: halt_i=1 on a matching compare at retired 7 -> DONE, retired_o=8; halt_i=1 on a data mismatch -> FAIL with kind 3.
REQ-033 Bench SHALL cover timeout: with COMMIT_CHK_TIMEOUT_EN and TIMEOUT=64, keep the FIFO empty for 64 RUN cycles -> FAIL, err_kind_o=3; reset in FAIL -> IDLE with all outputs 0.

Source files
------------

// File: rtl/commit_checker.sv
// commit_checker: lock-step retirement checker. A golden model pushes the
// events it expects into a small FIFO. Each DUT retire event is compared with
// the FIFO head. The block reports DONE after END_COUNT matching retirements,
// or after a matching retirement while halt_i is set. It reports FAIL on the
// first mismatch.
// Optional feature: define COMMIT_CHK_TIMEOUT_EN to add a watchdog. The
// watchdog fails the run after TIMEOUT RUN cycles with no compare.
module commit_checker #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 8,
    parameter int END_COUNT = 50,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exp_valid_i,
    output logic              exp_ready_o,
    input  logic [XLEN-1:0]   exp_pc_i,
    input  logic              exp_we_i,
    input  logic [REG_AW-1:0] exp_rd_i,
    input  logic [XLEN-1:0]   exp_wdata_i,
    input  logic              dut_valid_i,
    output logic              dut_ready_o,
    input  logic [XLEN-1:0]   dut_pc_i,
    input  logic              dut_we_i,
    input  logic [REG_AW-1:0] dut_rd_i,
    input  logic [XLEN-1:0]   dut_wdata_i,
    input  logic              halt_i,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_kind_o,
    output logic [15:0]       err_idx_o,
    output logic [15:0]       retired_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int ENT_W = XLEN + 1 + REG_AW + XLEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t            state_q;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_kind_q;
    logic [15:0]       err_idx_q;
    logic [15:0]       retired_q;
    logic [15:0]       retired_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              active;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   head_pc;
    logic              head_we;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_wdata;
    logic              head_we_eff;
    logic              dut_we_eff;
    logic [1:0]        cmp_kind;
    logic              match;
    logic              mismatch;
    logic              wd_expire;

    // The extra pointer MSB tells full from empty when the index bits are equal.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign active     = (state_q == IDLE) || (state_q == RUN);

    assign dut_ready_o = (state_q == RUN) && !fifo_empty;
    assign pop         = dut_valid_i && dut_ready_o;
    assign exp_ready_o = active && (!fifo_full || pop);
    assign push        = exp_valid_i && exp_ready_o;

    assign {head_pc, head_we, head_rd, head_wdata} = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A write to r0 is architecturally a no-op, so it is demoted to we=0 on both sides.
    assign head_we_eff = head_we && (head_rd != '0);
    assign dut_we_eff  = dut_we_i && (dut_rd_i != '0);

    // Classify the head/DUT pair: PC first, then we/rd, then data (only for real writes).
    always_comb begin
        cmp_kind = 2'd0;
        if (head_pc != dut_pc_i) begin
            cmp_kind = 2'd1;
        end else if ((head_we_eff != dut_we_eff) ||
                     (head_we_eff && (head_rd != dut_rd_i))) begin
            cmp_kind = 2'd2;
        end else if (head_we_eff && (head_wdata != dut_wdata_i)) begin
            cmp_kind = 2'd3;
        end
    end

    assign match     = pop && (cmp_kind == 2'd0);
    assign mismatch  = pop && (cmp_kind != 2'd0);
    assign retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

`ifdef COMMIT_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;

    assign wd_expire = (state_q == RUN) && !pop && (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog counts RUN cycles with no compare; any compare or leaving RUN clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != RUN) || pop) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Expected-event storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {exp_pc_i, exp_we_i, exp_rd_i, exp_wdata_i};
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Checker FSM with registered status outputs; a mismatch beats any DONE condition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_kind_q <= 2'd0;
            err_idx_q  <= 16'd0;
            retired_q  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exp_valid_i || dut_valid_i) state_q <= RUN;
                end
                RUN: begin
                    if (mismatch) begin
                        state_q    <= FAIL;
                        err_q      <= 1'b1;
                        err_kind_q <= cmp_kind;
                        err_idx_q  <= retired_q;
                    end else if (match) begin
                        retired_q <= retired_d;
                        if ((retired_d == 16'(END_COUNT)) || halt_i) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state_q    <= FAIL;
                        err_q      <= 1'b1;
                        err_kind_q <= 2'd3;
                        err_idx_q  <= retired_q;
                    end
                end
                DONE:    state_q <= DONE;
                FAIL:    state_q <= FAIL;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_kind_o = err_kind_q;
    assign err_idx_o  = err_idx_q;
    assign retired_o  = retired_q;

endmodule
